// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store unit behind the execute-stage ALU.
// It accepts one memory operation per handshake. It drives a single-outstanding
// req/ack bus with byte enables and lane-replicated store data. Each completion
// is returned to writeback as a one-cycle wb_valid pulse.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   -> a misaligned half/word access skips the bus and completes with wb_err
//   undefined -> the offending low address bits are cleared and the access proceeds
//
// Parameters: BUS_TIMEOUT - cycles in BUS without mem_ack before the access is
//             aborted with wb_err (0 disables the timeout)
// Ports:
//   clk, rst                       clock, async active-high reset
//   ex_valid/ex_ready              operation handshake (ready only in IDLE)
//   ex_load, ex_store, ex_func3    operation kind and RV32 width/sign code
//   ex_addr, ex_wdata, ex_rd       effective address, store data, load destination
//   mem_req/mem_ack                bus request held until ack or timeout
//   mem_we, mem_addr, mem_wdata,
//   mem_be, mem_rdata              bus write flag, word address, data, byte enables
//   wb_valid, wb_rd, wb_data,
//   wb_err                         completion pulse with held result fields
//   busy                           state is not IDLE
module load_store_unit #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_func3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_err,
    output logic        busy
);
    localparam int CNT_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic             accept, f3_legal, trap_misal;
    logic             go_bus, go_err, timeout;
    logic [3:0]       be_d;
    logic [31:0]      wdata_d;
    logic [1:0]       off_d;
    logic [4:0]       rd_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [31:0]      sh, ext;

    assign accept   = ex_valid & ex_ready & (ex_load | ex_store);
    assign ex_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign mem_req  = (state == BUS);
    assign wb_valid = (state == RESP);

    // Unsigned widths exist for loads only; a set load bit wins over store.
    always_comb begin
        f3_legal = 1'b0;
        case (ex_func3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = ex_load;
            default:                f3_legal = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_misal = ((ex_func3[1:0] == 2'b01) && ex_addr[0]) ||
                        ((ex_func3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
`else
    assign trap_misal = 1'b0;
`endif

    // Lane offset is always the naturally aligned one; when trapping, a
    // misaligned access never reaches the bus so the clearing is harmless.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = ex_wdata;
        off_d   = 2'b00;
        case (ex_func3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << ex_addr[1:0];
                wdata_d = {4{ex_wdata[7:0]}};
                off_d   = ex_addr[1:0];
            end
            2'b01: begin
                be_d    = 4'b0011 << {ex_addr[1], 1'b0};
                wdata_d = {2{ex_wdata[15:0]}};
                off_d   = {ex_addr[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        go_bus    = 1'b0;
        go_err    = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (!f3_legal || trap_misal) begin
                    go_err    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    go_bus    = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                // An ack in the last allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    state_nxt = RESP;
                end else if ((BUS_TIMEOUT != 0) && (cnt == CNT_W'(BUS_TIMEOUT - 1))) begin
                    timeout   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Load result: move the addressed lane to bit 0, then extend.
    assign sh = mem_rdata >> {off_q, 3'b000};
    always_comb begin
        case (f3_q[1:0])
            2'b00:   ext = {{24{~f3_q[2] & sh[7]}}, sh[7:0]};
            2'b01:   ext = {{16{~f3_q[2] & sh[15]}}, sh[15:0]};
            default: ext = sh;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            rd_q      <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            cnt       <= '0;
            wb_rd     <= '0;
            wb_data   <= '0;
            wb_err    <= 1'b0;
        end else begin
            if (go_bus) begin
                mem_we    <= ~ex_load;
                mem_addr  <= {ex_addr[31:2], 2'b00};
                mem_wdata <= wdata_d;
                mem_be    <= be_d;
                rd_q      <= ex_rd;
                f3_q      <= ex_func3;
                off_q     <= off_d;
                cnt       <= '0;
            end else if (state == BUS) begin
                cnt <= cnt + 1'b1;
            end

            if (go_err || timeout) begin
                wb_err  <= 1'b1;
                wb_rd   <= '0;
                wb_data <= '0;
            end else if ((state == BUS) && mem_ack) begin
                wb_err  <= 1'b0;
                wb_rd   <= mem_we ? 5'd0 : rd_q;
                wb_data <= mem_we ? 32'd0 : ext;
            end
        end
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit directly downstream of the execute-stage ALU. It accepts one memory operation per handshake, using the ALU sum as the effective byte address. It drives a single-outstanding request/acknowledge data bus with byte enables and aligned store data. It returns a sign- or zero-extended load result, or a store completion, to writeback as a one-cycle pulse.

## Interface
- `BUS_TIMEOUT`, 255: cycles spent in BUS without `mem_ack` before the access is aborted with an error; 0 disables the timeout.
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; asynchronous and active-high
- `ex_valid`  in  1  execute stage presents an operation
- `ex_ready`  out  1  LSU can accept; high only in IDLE
- `ex_load`  in  1  operation is a load
- `ex_store`  in  1  operation is a store
- `ex_func3`  in  3  RV32 width/sign code
- `ex_addr`  in  32  effective address (ALU result)
- `ex_wdata`  in  32  store data (rs2)
- `ex_rd`  in  5  load destination register
- `mem_req`  out  1  bus request, held until ack or abort
- `mem_we`  out  1  1 = write
- `mem_addr`  out  32  word address, bits [1:0] = 0
- `mem_wdata`  out  32  lane-replicated store data
- `mem_be`  out  4  byte enables
- `mem_ack`  in  1  bus completion; read data valid in the same cycle
- `mem_rdata`  in  32  read word
- `wb_valid`  out  1  one-cycle completion pulse
- `wb_rd`  out  5  destination register; 0 for stores and errors
- `wb_data`  out  32  extended load data; 0 for stores and errors
- `wb_err`  out  1  misaligned, illegal func3, or timeout
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- **States:** IDLE, BUS, RESP.
- **Accept:** when `ex_valid & ex_ready & (ex_load | ex_store)`. All operands are registered on acceptance.
  - `ex_valid` without load or store is ignored.
  - If both `ex_load` and `ex_store` are high, the operation is a load.
- **func3 decode:**
  - 000 = byte.
  - 001 = half.
  - 010 = word.
  - 100 = unsigned byte, loads only.
  - 101 = unsigned half, loads only.
  - Any other code, or 100/101 on a store, is illegal: IDLE→RESP with `wb_err`=1 and no bus access.
- **Byte enables:**
  - Byte: `mem_be` = 0001 << addr[1:0], `mem_wdata` = {4{wdata[7:0]}}.
  - Half: `mem_be` = 0011 << {addr[1],0}, `mem_wdata` = {2{wdata[15:0]}}.
  - Word: `mem_be` = 1111, `mem_wdata` = wdata.
  - Loads drive `mem_be` the same way; `mem_we`=0.
- **Load extraction:** `mem_rdata` >> (8·addr[1:0]), then sign- or zero-extend from 8 or 16 bits.
- **Misaligned:** a half access with addr[0]=1, or a word access with addr[1:0]≠0 (see Configuration).
- **BUS state:** `mem_req`=1 every cycle.
  - On `mem_ack`: capture the result and go to RESP.
  - A cycle counter counts up from 0 on BUS entry. When it reaches `BUS_TIMEOUT` without `mem_ack`: drop `mem_req`, go to RESP with `wb_err`=1.
- **RESP state:** `wb_valid`=1 for exactly one cycle, then IDLE.
- **Ignored acks:** `mem_ack` in IDLE or RESP has no effect.
- **Reset values:** state IDLE, counter 0, and every output 0 except `ex_ready`=1. This holds for reset in any state, including mid-BUS: `mem_req` falls asynchronously.

## Timing
- Accept at cycle 0 → `mem_req` high from cycle 1. All `mem_*` outputs are registered and stable while `mem_req` is high.
- `mem_ack` at cycle N (N≥1) → `wb_valid` at cycle N+1.
- Minimum latency, accept to `wb_valid`, is 2 cycles.
- An error detected at accept (illegal func3, or misaligned with the trap enabled) → `wb_valid` with `wb_err` at cycle 1.
- Timeout → `mem_req` low at cycle `BUS_TIMEOUT`+1, `wb_valid` at the same cycle.
- `ex_ready` is low from cycle 1 through the RESP cycle. The next accept is possible the cycle after RESP.
- `wb_*` outputs hold their values until the next RESP; only `wb_valid` is pulsed.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:** a misaligned access performs no bus access. The LSU goes IDLE→RESP with `wb_err`=1, `wb_rd`=0 and `wb_data`=0.
- **`LSU_MISALIGN_TRAP_EN` undefined:** the offending low address bits are cleared before use (half: addr[0]=0; word: addr[1:0]=0). The access proceeds normally with `wb_err`=0.

## Test plan
- Store byte: addr 0x1003, wdata 0xA5, func3 000 → `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_addr`=0x1000, `mem_we`=1. Ack in cycle 1 → `wb_valid` in cycle 2 with `wb_rd`=0.
- Load byte signed and unsigned: `mem_rdata`=0x80FF7F01 at addr offset 3.
  - func3 000 (byte) → `wb_data`=0xFFFFFF80.
  - func3 100 (unsigned byte) → `wb_data`=0x00000080.
  - Offset 2, func3 101 → `wb_data`=0x000080FF.
- Ack delayed 5 cycles → `mem_req` is held with stable address for 5 cycles, `ex_ready`=0 throughout, and `wb_valid` fires the cycle after the ack.
- `BUS_TIMEOUT`=4 with no ack → `mem_req` drops and `wb_valid`=1 with `wb_err`=1 and `wb_data`=0 at cycle 5.
- Load word at addr 0x2002:
  - With the macro defined → no `mem_req`; `wb_err` at cycle 1.
  - With the macro undefined → `mem_addr`=0x2000, `wb_err`=0.
- Assert `rst` while in BUS → `mem_req`=0 immediately and `ex_ready`=1. A subsequent accept completes normally; a stale `mem_ack` arriving while in IDLE is ignored.
